// File: rtl/x2050mpx_pkg.sv
// Shared definitions for the multiplexor-channel routine logic.
//   RQ_A..RQ_D       routine quadrant codes (code[4:3])
//   LVL_PCI/P2/P3    request levels; level 3 is reserved and ranks as LVL_P3
//   rtne_state_e     scheduler FSM states
//   rtne_decode()    routine code -> one-hot {quad, bit}; also used by the channel-0 control
package x2050mpx_pkg;

    localparam logic [1:0] RQ_A = 2'd0;
    localparam logic [1:0] RQ_B = 2'd1;
    localparam logic [1:0] RQ_C = 2'd2;
    localparam logic [1:0] RQ_D = 2'd3;

    localparam logic [1:0] LVL_PCI = 2'd0;
    localparam logic [1:0] LVL_P2  = 2'd1;
    localparam logic [1:0] LVL_P3  = 2'd2;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } rtne_state_e;

    typedef struct packed {
        logic [3:0] quad;
        logic [7:0] bits;
    } rtne_dec_t;

    function automatic rtne_dec_t rtne_decode(input logic [4:0] code);
        rtne_dec_t d;
        d.quad = '0;
        unique case (code[4:3])
            RQ_A: d.quad = 4'b0001;
            RQ_B: d.quad = 4'b0010;
            RQ_C: d.quad = 4'b0100;
            RQ_D: d.quad = 4'b1000;
        endcase
        d.bits = 8'b0000_0001 << code[2:0];
        return d;
    endfunction

endpackage

// File: rtl/x2050mpx_rtne_sched_if.sv
// Request/grant bundle between the subchannel request sources (master) and the routine
// scheduler (slave).
//   inputs : i_ros_advance, i_req_set/code/pri/cancel, i_early_first_cycle, i_routine_done
//   outputs: o_rtne_valid/req_buffer/sub/pri, o_quad, o_bit, o_pending, level summaries, o_overrun
interface x2050mpx_rtne_sched_if #(
    parameter int unsigned NSUB   = 4,
    parameter int unsigned CODE_W = 5
);
    localparam int unsigned SUB_W = $clog2(NSUB);

    logic                     i_ros_advance;
    logic [NSUB-1:0]          i_req_set;
    logic [NSUB*CODE_W-1:0]   i_req_code;
    logic [NSUB*2-1:0]        i_req_pri;
    logic [NSUB-1:0]          i_req_cancel;
    logic                     i_early_first_cycle;
    logic                     i_routine_done;

    logic                     o_rtne_valid;
    logic [CODE_W-1:0]        o_rtne_req_buffer;
    logic [SUB_W-1:0]         o_rtne_sub;
    logic [1:0]               o_rtne_pri;
    logic [3:0]               o_quad;
    logic [7:0]               o_bit;
    logic [NSUB-1:0]          o_pending;
    logic                     o_pci_request;
    logic                     o_priority_2;
    logic                     o_priority_3;
    logic [NSUB-1:0]          o_overrun;

    modport master (
        output i_ros_advance, i_req_set, i_req_code, i_req_pri, i_req_cancel,
               i_early_first_cycle, i_routine_done,
        input  o_rtne_valid, o_rtne_req_buffer, o_rtne_sub, o_rtne_pri, o_quad, o_bit,
               o_pending, o_pci_request, o_priority_2, o_priority_3, o_overrun
    );

    modport slave (
        input  i_ros_advance, i_req_set, i_req_code, i_req_pri, i_req_cancel,
               i_early_first_cycle, i_routine_done,
        output o_rtne_valid, o_rtne_req_buffer, o_rtne_sub, o_rtne_pri, o_quad, o_bit,
               o_pending, o_pci_request, o_priority_2, o_priority_3, o_overrun
    );

endinterface

// File: rtl/x2050mpx_rr_pick.sv
// Rotating priority encoder: first set bit of mask_i scanning upward from ptr_i, wrapping
// NSUB-1 -> 0.
//   mask_i  candidate subchannels
//   ptr_i   scan start index
//   hit_o   any candidate present
//   idx_o   selected subchannel index (0 when !hit_o)
module x2050mpx_rr_pick #(
    parameter int unsigned NSUB = 4
) (
    input  logic [NSUB-1:0]         mask_i,
    input  logic [$clog2(NSUB)-1:0] ptr_i,
    output logic                    hit_o,
    output logic [$clog2(NSUB)-1:0] idx_o
);
    localparam int unsigned SUB_W = $clog2(NSUB);

    logic [SUB_W-1:0] cand;

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NSUB; i++) begin
            cand = SUB_W'((32'(ptr_i) + i) % NSUB);
            if (!hit_o && mask_i[cand]) begin
                hit_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/x2050mpx_rtne_sched.sv
// Routine-request scheduler for the multiplexor channel.
// Holds one pending request per subchannel, grants one on the early-first-cycle strobe
// (lowest level first, round-robin within a level) and presents the buffered routine code
// plus its quadrant/bit one-hot decode to the microcode branch logic.
//   i_clk, i_reset  clock, synchronous active-high reset
//   bus (slave)     request inputs, ROS advance qualifier, strobe/done, grant buffer,
//                   decodes, pending/level summaries and sticky overrun flags
module x2050mpx_rtne_sched
    import x2050mpx_pkg::*;
#(
    parameter int unsigned NSUB   = 4,
    parameter int unsigned CODE_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    x2050mpx_rtne_sched_if.slave  bus
);
    localparam int unsigned SUB_W = $clog2(NSUB);

    logic [NSUB-1:0]   pending_q, pending_d;
    logic [NSUB-1:0]   overrun_q, overrun_d;
    logic [CODE_W-1:0] code_q [NSUB];
    logic [CODE_W-1:0] code_d [NSUB];
    logic [1:0]        lvl_q  [NSUB];
    logic [1:0]        lvl_d  [NSUB];
    logic [SUB_W-1:0]  rr_q, rr_d;
    rtne_state_e       state_q, state_d;
    logic [CODE_W-1:0] buf_code_q, buf_code_d;
    logic [SUB_W-1:0]  buf_sub_q, buf_sub_d;
    logic [1:0]        buf_pri_q, buf_pri_d;

    logic [NSUB-1:0]   lvl_mask [3];
    logic [2:0]        lvl_hit;
    logic [SUB_W-1:0]  lvl_idx  [3];
    logic              win_hit;
    logic [SUB_W-1:0]  win_idx;
    logic              grant;
    rtne_dec_t         dec;

    // Pending requests split by level; reserved level 3 ranks with prio3.
    always_comb begin
        for (int g = 0; g < 3; g++) lvl_mask[g] = '0;
        for (int s = 0; s < NSUB; s++) begin
            lvl_mask[0][s] = pending_q[s] && (lvl_q[s] == LVL_PCI);
            lvl_mask[1][s] = pending_q[s] && (lvl_q[s] == LVL_P2);
            lvl_mask[2][s] = pending_q[s] && (lvl_q[s] >= LVL_P3);
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_lvl
        x2050mpx_rr_pick #(.NSUB(NSUB)) u_pick (
            .mask_i (lvl_mask[g]),
            .ptr_i  (rr_q),
            .hit_o  (lvl_hit[g]),
            .idx_o  (lvl_idx[g])
        );
    end

    always_comb begin
        win_hit = |lvl_hit;
        win_idx = lvl_idx[2];
        if (lvl_hit[0])      win_idx = lvl_idx[0];
        else if (lvl_hit[1]) win_idx = lvl_idx[1];
    end

    // A strobe while BUSY only grants when it coincides with routine done (back-to-back).
    assign grant = bus.i_early_first_cycle && win_hit &&
                   ((state_q == StIdle) || bus.i_routine_done);

    always_comb begin
        state_d    = state_q;
        buf_code_d = buf_code_q;
        buf_sub_d  = buf_sub_q;
        buf_pri_d  = buf_pri_q;
        rr_d       = rr_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = StBusy;
            StBusy:  if (bus.i_routine_done) state_d = grant ? StBusy : StIdle;
            default: state_d = StIdle;
        endcase
        if (grant) begin
            buf_code_d = code_q[win_idx];
            buf_sub_d  = win_idx;
            buf_pri_d  = lvl_q[win_idx];
            rr_d       = (32'(win_idx) == NSUB - 1) ? '0 : win_idx + 1'b1;
        end
    end

    // Latch priority: set > cancel > grant-clear.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        for (int s = 0; s < NSUB; s++) begin
            logic [1:0] new_lvl;
            new_lvl   = bus.i_req_pri[s*2 +: 2];
            code_d[s] = code_q[s];
            lvl_d[s]  = lvl_q[s];
            if (bus.i_req_set[s]) begin
                pending_d[s] = 1'b1;
                if (!pending_q[s] || new_lvl <= lvl_q[s]) begin
                    code_d[s] = bus.i_req_code[s*CODE_W +: CODE_W];
                    lvl_d[s]  = new_lvl;
                end
                if (pending_q[s]) overrun_d[s] = 1'b1;
            end else if (bus.i_req_cancel[s]) begin
                pending_d[s] = 1'b0;
            end else if (grant && (win_idx == SUB_W'(s))) begin
                pending_d[s] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pending_q  <= '0;
            overrun_q  <= '0;
            rr_q       <= '0;
            state_q    <= StIdle;
            buf_code_q <= '0;
            buf_sub_q  <= '0;
            buf_pri_q  <= '0;
            for (int s = 0; s < NSUB; s++) begin
                code_q[s] <= '0;
                lvl_q[s]  <= '0;
            end
        end else if (bus.i_ros_advance) begin
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            rr_q       <= rr_d;
            state_q    <= state_d;
            buf_code_q <= buf_code_d;
            buf_sub_q  <= buf_sub_d;
            buf_pri_q  <= buf_pri_d;
            for (int s = 0; s < NSUB; s++) begin
                code_q[s] <= code_d[s];
                lvl_q[s]  <= lvl_d[s];
            end
        end
    end

    assign dec                   = rtne_decode(buf_code_q[4:0]);
    assign bus.o_rtne_valid      = (state_q == StBusy);
    assign bus.o_rtne_req_buffer = buf_code_q;
    assign bus.o_rtne_sub        = buf_sub_q;
    assign bus.o_rtne_pri        = buf_pri_q;
    assign bus.o_quad            = bus.o_rtne_valid ? dec.quad : 4'h0;
    assign bus.o_bit             = bus.o_rtne_valid ? dec.bits : 8'h00;
    assign bus.o_pending         = pending_q;
    assign bus.o_overrun         = overrun_q;
    assign bus.o_pci_request     = |lvl_mask[0];
    assign bus.o_priority_2      = |lvl_mask[1];
    assign bus.o_priority_3      = |lvl_mask[2];

endmodule
